// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the block memory controllers: FSM states and the
// beat/offset geometry of a 128-bit cache block carried as four 32-bit words.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BEATS     = 4;
    localparam int BEAT_W    = 2;
    localparam int BYTE_W    = 2;
    localparam int OFF_W     = BEAT_W + BYTE_W;
    localparam int LAT_W     = 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Byte offset of a beat inside its block; the block base never carries into it.
    function automatic logic [OFF_W-1:0] beat_offset(input logic [BEAT_W-1:0] beat);
        return {beat, {BYTE_W{1'b0}}};
    endfunction

endpackage

// File: rtl/block_refill_ctrl.sv
// Moves one cache block between the cache and a word-wide data memory:
// refill reads gather BEATS words, write-backs scatter them, after a fixed wait.
module block_refill_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WA        = 32,
    parameter int WD        = 32,
    parameter int BLOCKSIZE = 128,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [WA-1:0]        req_addr,
    input  logic [BLOCKSIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [BLOCKSIZE-1:0] resp_rdata,
    output logic                 busy,
    output logic [WA-1:0]        ram_addr,
    output logic                 ram_we,
    output logic [WD-1:0]        ram_wdata,
    input  logic [WD-1:0]        ram_rdata
);

    localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY == 0) ? LAT_W'(0) : LAT_W'(LATENCY - 1);

    state_t                r_state;
    logic [LAT_W-1:0]      r_wait_cnt;
    logic [BEAT_W-1:0]     r_beat;
    logic                  r_write;
    logic [WA-1:0]         r_base;
    logic [BLOCKSIZE-1:0]  r_wdata;
    logic [BLOCKSIZE-1:0]  r_rdata;
    logic                  r_resp_valid;
    logic                  r_ram_we;
    logic [WA-1:0]         r_ram_addr;
    logic [WD-1:0]         r_ram_wdata;

    logic [WA-1:0]         w_req_base;
    logic [BEAT_W-1:0]     w_beat_next;
    logic [WD-1:0]         w_words [BEATS];
    logic                  w_unused_addr;

    assign w_req_base    = {req_addr[WA-1:OFF_W], {OFF_W{1'b0}}};
    assign w_beat_next   = r_beat + BEAT_W'(1);
    assign w_unused_addr = ^req_addr[OFF_W-1:0];

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
        assign w_words[gi] = r_wdata[gi*WD +: WD];
    end

    // RAM-side signals are registered so each beat's address/data/we line up
    // with the XFER cycle they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_beat       <= '0;
            r_write      <= 1'b0;
            r_base       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_base     <= w_req_base;
                        r_write    <= req_write;
                        r_wdata    <= req_wdata;
                        r_ram_addr <= w_req_base;
                        r_beat     <= '0;
                        if (LATENCY == 0) begin
                            r_state     <= XFER;
                            r_ram_we    <= req_write;
                            r_ram_wdata <= req_wdata[WD-1:0];
                        end else begin
                            r_state    <= WAIT;
                            r_wait_cnt <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state     <= XFER;
                        r_ram_we    <= r_write;
                        r_ram_wdata <= w_words[0];
                    end else begin
                        r_wait_cnt <= r_wait_cnt - LAT_W'(1);
                    end
                end
                XFER: begin
                    if (!r_write) begin
                        r_rdata[int'(r_beat)*WD +: WD] <= ram_rdata;
                    end
                    if (r_beat == LAST_BEAT) begin
                        r_state      <= DONE;
                        r_beat       <= '0;
                        r_ram_we     <= 1'b0;
                        r_ram_addr   <= r_base;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_beat      <= w_beat_next;
                        r_ram_addr  <= {r_base[WA-1:OFF_W], beat_offset(w_beat_next)};
                        r_ram_wdata <= w_words[w_beat_next];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_block_refill_ctrl.sv
// Scoreboard bench for block_refill_ctrl: one instance with LATENCY=4 and one
// with LATENCY=0, each attached to a small word RAM.
module tb_block_refill_ctrl;

    localparam int N     = 2;
    localparam int BEATS = 4;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst        [N];
    logic         req_valid  [N];
    logic         req_write  [N];
    logic [31:0]  req_addr   [N];
    logic [127:0] req_wdata  [N];
    logic         req_ready  [N];
    logic         resp_valid [N];
    logic [127:0] resp_rdata [N];
    logic         busy       [N];
    logic [31:0]  ram_addr   [N];
    logic         ram_we     [N];
    logic [31:0]  ram_wdata  [N];
    logic [31:0]  ram_rdata  [N];
    logic [31:0]  ram        [N][256];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        block_refill_ctrl #(
            .WA        (32),
            .WD        (32),
            .BLOCKSIZE (128),
            .LATENCY   ((gi == 0) ? 4 : 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[gi]),
            .req_valid  (req_valid[gi]),
            .req_write  (req_write[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .req_ready  (req_ready[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_rdata (resp_rdata[gi]),
            .busy       (busy[gi]),
            .ram_addr   (ram_addr[gi]),
            .ram_we     (ram_we[gi]),
            .ram_wdata  (ram_wdata[gi]),
            .ram_rdata  (ram_rdata[gi])
        );
        assign ram_rdata[gi] = ram[gi][ram_addr[gi][9:2]];
    end

    // Reference model state
    int           cyc   = 0;
    int           total = 0;
    int           bad   = 0;
    bit           mon_en = 1'b0;
    beat_t        beat_q [N][$];
    resp_t        resp_q [N][$];
    int           done_cyc   [N];
    int           base_cyc   [N];
    logic [31:0]  old_base   [N];
    logic [31:0]  new_base   [N];
    logic [127:0] last_rdata [N];
    logic [31:0]  ref_mem    [N][256];

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    task automatic check(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, exp);
        end
    endtask

    // Word RAM: combinational read, write on the rising edge.
    initial begin
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 256; i++) begin
                ram[k][i]     = 32'h60 + 32'(i);
                ref_mem[k][i] = 32'h60 + 32'(i);
            end
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < N; k++) begin
                if (ram_we[k]) ram[k][ram_addr[k][9:2]] <= ram_wdata[k];
            end
        end
    end

    task automatic monitor_tick(input int k);
        beat_t b;
        resp_t r;
        bit    exp_busy;
        bit    exp_rv;
        exp_busy = (cyc <= done_cyc[k]);
        check("busy", k, 128'(busy[k]), 128'(exp_busy));
        check("req_ready", k, 128'(req_ready[k]), 128'(!exp_busy));
        if (beat_q[k].size() > 0 && beat_q[k][0].cyc == cyc) begin
            b = beat_q[k].pop_front();
            check("beat_addr", k, 128'(ram_addr[k]), 128'(b.addr));
            check("beat_we", k, 128'(ram_we[k]), 128'(b.we));
            if (b.we) begin
                check("beat_wdata", k, 128'(ram_wdata[k]), 128'(b.data));
                ref_mem[k][b.addr[9:2]] = b.data;
            end
        end else begin
            check("idle_we", k, 128'(ram_we[k]), 128'(0));
            check("idle_addr", k, 128'(ram_addr[k]),
                  128'((cyc >= base_cyc[k]) ? new_base[k] : old_base[k]));
        end
        exp_rv = (resp_q[k].size() > 0 && resp_q[k][0].cyc == cyc);
        check("resp_valid", k, 128'(resp_valid[k]), 128'(exp_rv));
        if (exp_rv) begin
            r = resp_q[k].pop_front();
            check("resp_rdata", k, resp_rdata[k], r.data);
        end else if (!exp_busy) begin
            check("held_rdata", k, resp_rdata[k], last_rdata[k]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                for (int k = 0; k < N; k++) monitor_tick(k);
            end
        end
    end

    // Raise a request and hold it until the model says the controller is idle.
    task automatic issue(input int k, input bit wr, input logic [31:0] addr,
                         input logic [127:0] wd, output int acc);
        int           waited;
        int           lat;
        logic [31:0]  base;
        logic [127:0] expd;
        beat_t        b;
        resp_t        r;
        waited = 0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        while (cyc <= done_cyc[k] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            total++;
            bad++;
            $display("FAIL issue_wait dut%0d cyc=%0d actual=timeout required=idle", k, cyc);
        end
        lat  = lat_of(k);
        acc  = cyc + 1;
        base = addr & 32'hFFFF_FFF0;
        expd = '0;
        for (int i = 0; i < BEATS; i++) begin
            b.cyc  = acc + lat + i;
            b.addr = base | 32'(4 * i);
            b.we   = wr;
            b.data = wd[32*i +: 32];
            beat_q[k].push_back(b);
            expd[32*i +: 32] = ref_mem[k][b.addr[9:2]];
        end
        r.cyc  = acc + lat + BEATS;
        r.data = wr ? last_rdata[k] : expd;
        resp_q[k].push_back(r);
        if (!wr) last_rdata[k] = expd;
        done_cyc[k] = r.cyc;
        old_base[k] = new_base[k];
        new_base[k] = base;
        base_cyc[k] = acc;
        $display("txn dut%0d %s addr=%h wdata=%h accept_cyc=%0d", k, wr ? "wr" : "rd", addr, wd, acc);
        @(posedge clk);
    endtask

    task automatic drop(input int k);
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cyc <= done_cyc[0] || cyc <= done_cyc[1]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain cyc=%0d actual=busy required=idle", cyc);
        end
    endtask

    // Write-back aborted by reset while beat 2 is on the RAM bus.
    task automatic abort_write(input int k, input logic [31:0] addr, input logic [127:0] wd);
        int acc;
        issue(k, 1'b1, addr, wd, acc);
        while (cyc < acc + lat_of(k) + 2) @(negedge clk);
        rst[k]       = 1'b1;
        req_valid[k] = 1'b0;
        beat_q[k].delete();
        resp_q[k].delete();
        done_cyc[k]   = cyc;
        last_rdata[k] = '0;
        old_base[k]   = new_base[k];
        new_base[k]   = '0;
        base_cyc[k]   = cyc + 1;
        $display("txn dut%0d reset during beat 2 at cyc=%0d", k, cyc);
        @(negedge clk);
        rst[k] = 1'b0;
    endtask

    initial begin
        int           acc;
        bit           wr;
        logic [31:0]  a;
        logic [127:0] v;
        for (int k = 0; k < N; k++) begin
            rst[k]        = 1'b1;
            req_valid[k]  = 1'b1;
            req_write[k]  = 1'b0;
            req_addr[k]   = 32'h0000_0500;
            req_wdata[k]  = '0;
            done_cyc[k]   = -1;
            base_cyc[k]   = 0;
            old_base[k]   = '0;
            new_base[k]   = '0;
            last_rdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_resp_valid", k, 128'(resp_valid[k]), 128'(0));
            check("rst_resp_rdata", k, resp_rdata[k], 128'(0));
            check("rst_ram_addr", k, 128'(ram_addr[k]), 128'(0));
            check("rst_ram_we", k, 128'(ram_we[k]), 128'(0));
            check("rst_ram_wdata", k, 128'(ram_wdata[k]), 128'(0));
            check("rst_busy", k, 128'(busy[k]), 128'(0));
            check("rst_req_ready", k, 128'(req_ready[k]), 128'(1));
            rst[k]       = 1'b0;
            req_valid[k] = 1'b0;
        end
        mon_en = 1'b1;

        // Refill of the block at 0x100
        issue(0, 1'b0, 32'h0000_0104, '0, acc);
        drop(0);
        drain();
        check("refill_data", 0, resp_rdata[0], 128'h000000A3_000000A2_000000A1_000000A0);

        // Write-back to 0x200
        issue(0, 1'b1, 32'h0000_0200, 128'h00000044_00000033_00000022_00000011, acc);
        drop(0);
        drain();
        check("wb_keeps_rdata", 0, resp_rdata[0], 128'h000000A3_000000A2_000000A1_000000A0);
        for (int i = 0; i < BEATS; i++) begin
            check("wb_ram_word", 0, 128'(ram[0][128 + i]), 128'(32'h11 * (i + 1)));
        end

        // Second request held high throughout the first transfer
        issue(0, 1'b0, 32'h0000_0300, '0, acc);
        issue(0, 1'b0, 32'h0000_0100, '0, acc);
        drop(0);
        drain();

        abort_write(0, 32'h0000_0400, {4{32'hDEAD_BEEF}});
        drain();

        // Zero-latency instance, block at the top of the address space
        issue(1, 1'b0, 32'hFFFF_FFF8, '0, acc);
        drop(1);
        drain();
        check("wrap_data", 1, resp_rdata[1], {32'h15F, 32'h15E, 32'h15D, 32'h15C});

        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 30; t++) begin
                wr = 1'($urandom_range(0, 1));
                a  = ($urandom() & 32'hFFFF_FC0F) | (32'($urandom_range(0, 7)) << 4);
                v  = {$urandom(), $urandom(), $urandom(), $urandom()};
                issue(k, wr, a, v, acc);
                if ($urandom_range(0, 3) != 0) begin
                    drop(k);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            drop(k);
            drain();
        end

        drain();
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("scoreboard_empty", k, 128'(beat_q[k].size() + resp_q[k].size()), 128'(0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
